// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman exchange sequencer.
//   state_t     : top-level exchange FSM states
//   hs_stage_t  : which engine handshake step the sequencer is in
//   ERR_*       : err_code values reported to the host
//   DEFAULT_WIDTH : default operand / modulus width
package dh_pkg;

   localparam int DEFAULT_WIDTH = 100;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_PUB_START,
      S_PUB_ACK,
      S_PUB_RUN,
      S_WAIT_PEER,
      S_SEC_START,
      S_SEC_ACK,
      S_SEC_RUN,
      S_DONE,
      S_ERR
   } state_t;

   // Both exchange phases drive the engine through the same three steps,
   // so the handshake block only needs to know which step is active.
   typedef enum logic [1:0] {
      HS_IDLE,
      HS_START,
      HS_ACK,
      HS_RUN
   } hs_stage_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_PRIME   = 2'd1;
   localparam logic [1:0] ERR_PEER    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/dh_exchange_ctrl_me_handshake.sv
// Engine handshake helper shared by the public-key and shared-secret phases.
// The top maps whichever phase is active onto a single stage select, so one
// counter and one edge detector serve both engine runs.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : drop the counter (exchange aborted)
//   stage        : HS_START / HS_ACK / HS_RUN of the active phase, else HS_IDLE
//   dirty        : engine busy flag
//   start_done   : last cycle of the START_CYCLES-long start pulse
//   ack_seen     : engine raised dirty while waiting for it
//   ack_timeout  : ACK_TIMEOUT cycles passed without dirty
//   dirty_fall   : registered dirty 1->0 while the engine runs
module me_handshake
   import dh_pkg::*;
#(
   parameter int START_CYCLES = 2,
   parameter int ACK_TIMEOUT  = 16
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      clear,
   input  hs_stage_t stage,
   input  logic      dirty,
   output logic      start_done,
   output logic      ack_seen,
   output logic      ack_timeout,
   output logic      dirty_fall
);

   localparam int CNT_MAX = (START_CYCLES > ACK_TIMEOUT) ? START_CYCLES : ACK_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic [CW-1:0] cnt;
   logic          dirty_q;
   logic          counting;

   // NOTE: every output of this block gets a value on every path, so no latch
   // can be inferred; a missing else in always_comb would build one.
   always_comb begin
      counting    = (stage == HS_START) || (stage == HS_ACK);
      start_done  = (stage == HS_START) && (cnt == CW'(START_CYCLES - 1));
      ack_seen    = (stage == HS_ACK) && dirty;
      ack_timeout = (stage == HS_ACK) && !dirty && (cnt == CW'(ACK_TIMEOUT - 1));
      dirty_fall  = (stage == HS_RUN) && dirty_q && !dirty;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         dirty_q <= 1'b0;
      end else begin
         // dirty is tracked in every state so the falling edge is clean on
         // the first RUN cycle.
         dirty_q <= dirty;
         // The counter restarts at 0 on every step change, giving each START
         // and ACK step its own count from 0.
         if (clear || !counting || start_done || ack_seen || ack_timeout)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/dh_exchange_ctrl.sv
// Sequencer for one Diffie-Hellman exchange on a shared modular_exp engine.
// Phase 1 computes A = g^a mod p, phase 2 validates the peer key B and
// computes s = B^a mod p. The engine itself lives outside this block.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start                    : begin an exchange (honoured in IDLE/DONE/ERR)
//   generator, prime, priv_key : g, p, a, captured on an accepted start
//   peer_pub, peer_valid     : peer key B and its strobe (used in WAIT_PEER)
//   abort                    : synchronous return to IDLE, beats start/peer_valid
//   busy                     : exchange in progress (not IDLE/DONE/ERR)
//   pub_key, pub_valid       : local public key A and its level-valid
//   secret, secret_valid     : shared secret s and its level-valid
//   error, err_code          : failure flag and reason (dh_pkg ERR_*)
//   me_start                 : engine start pulse (engine rst pin)
//   me_base, me_exp, me_prime: registered engine operands
//   me_result, me_dirty      : engine result and busy flag
module dh_exchange_ctrl
   import dh_pkg::*;
#(
   parameter int WIDTH        = DEFAULT_WIDTH,
   parameter int START_CYCLES = 2,
   parameter int ACK_TIMEOUT  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] generator,
   input  logic [WIDTH-1:0] prime,
   input  logic [WIDTH-1:0] priv_key,
   input  logic [WIDTH-1:0] peer_pub,
   input  logic             peer_valid,
   input  logic             abort,
   output logic             busy,
   output logic [WIDTH-1:0] pub_key,
   output logic             pub_valid,
   output logic [WIDTH-1:0] secret,
   output logic             secret_valid,
   output logic             error,
   output logic [1:0]       err_code,
   output logic             me_start,
   output logic [WIDTH-1:0] me_base,
   output logic [WIDTH:0]   me_exp,
   output logic [WIDTH-1:0] me_prime,
   input  logic [WIDTH-1:0] me_result,
   input  logic             me_dirty
);

   state_t           state, state_next;
   hs_stage_t        hs_stage;
   logic [WIDTH-1:0] g_q, p_q, a_q;

   logic hs_start_done, hs_ack_seen, hs_timeout, hs_dirty_fall;
   logic load_cfg, load_pub_ops, load_sec_ops;
   logic cap_pub, cap_sec, clr_status, set_err;
   logic [1:0] err_sel;
   logic peer_bad;

   // 0 and 1 are degenerate keys; anything at or above p is not a residue.
   assign peer_bad = (peer_pub <= WIDTH'(1)) || (peer_pub >= p_q);

   assign busy = !(state inside {S_IDLE, S_DONE, S_ERR});

   // Abort kills the start pulse in the same cycle, not one cycle later.
   assign me_start = (hs_stage == HS_START) && !abort;

   always_comb begin
      hs_stage = HS_IDLE;
      unique case (state)
         S_PUB_START, S_SEC_START: hs_stage = HS_START;
         S_PUB_ACK,   S_SEC_ACK:   hs_stage = HS_ACK;
         S_PUB_RUN,   S_SEC_RUN:   hs_stage = HS_RUN;
         default:                  hs_stage = HS_IDLE;
      endcase
   end

   me_handshake #(
      .START_CYCLES (START_CYCLES),
      .ACK_TIMEOUT  (ACK_TIMEOUT)
   ) u_handshake (
      .clk         (clk),
      .rst         (rst),
      .clear       (abort),
      .stage       (hs_stage),
      .dirty       (me_dirty),
      .start_done  (hs_start_done),
      .ack_seen    (hs_ack_seen),
      .ack_timeout (hs_timeout),
      .dirty_fall  (hs_dirty_fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next   = state;
      load_cfg     = 1'b0;
      load_pub_ops = 1'b0;
      load_sec_ops = 1'b0;
      cap_pub      = 1'b0;
      cap_sec      = 1'b0;
      clr_status   = 1'b0;
      set_err      = 1'b0;
      err_sel      = ERR_NONE;

      if (abort) begin
         state_next = S_IDLE;
         clr_status = 1'b1;
      end else begin
         unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  load_cfg   = 1'b1;
                  clr_status = 1'b1;
                  state_next = S_CHECK;
               end
            end
            S_CHECK: begin
               if (p_q < WIDTH'(3)) begin
                  set_err    = 1'b1;
                  err_sel    = ERR_PRIME;
                  state_next = S_ERR;
               end else begin
                  load_pub_ops = 1'b1;
                  state_next   = S_PUB_START;
               end
            end
            S_PUB_START: if (hs_start_done) state_next = S_PUB_ACK;
            S_PUB_ACK: begin
               if (hs_ack_seen) begin
                  state_next = S_PUB_RUN;
               end else if (hs_timeout) begin
                  set_err    = 1'b1;
                  err_sel    = ERR_TIMEOUT;
                  state_next = S_ERR;
               end
            end
            S_PUB_RUN: begin
               if (hs_dirty_fall) begin
                  cap_pub    = 1'b1;
                  state_next = S_WAIT_PEER;
               end
            end
            S_WAIT_PEER: begin
               if (peer_valid) begin
                  if (peer_bad) begin
                     set_err    = 1'b1;
                     err_sel    = ERR_PEER;
                     state_next = S_ERR;
                  end else begin
                     load_sec_ops = 1'b1;
                     state_next   = S_SEC_START;
                  end
               end
            end
            S_SEC_START: if (hs_start_done) state_next = S_SEC_ACK;
            S_SEC_ACK: begin
               if (hs_ack_seen) begin
                  state_next = S_SEC_RUN;
               end else if (hs_timeout) begin
                  set_err    = 1'b1;
                  err_sel    = ERR_TIMEOUT;
                  state_next = S_ERR;
               end
            end
            S_SEC_RUN: begin
               if (hs_dirty_fall) begin
                  cap_sec    = 1'b1;
                  state_next = S_DONE;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   // NOTE: every register here, operands included, is in the async reset so
   // the block comes up fully defined; there is no array storage to exempt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g_q          <= '0;
         p_q          <= '0;
         a_q          <= '0;
         me_base      <= '0;
         me_exp       <= '0;
         me_prime     <= '0;
         pub_key      <= '0;
         pub_valid    <= 1'b0;
         secret       <= '0;
         secret_valid <= 1'b0;
         error        <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         if (clr_status) begin
            pub_valid    <= 1'b0;
            secret_valid <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
         end
         if (load_cfg) begin
            g_q <= generator;
            p_q <= prime;
            a_q <= priv_key;
         end
         // Operands are loaded on the edge entering a START state and then
         // left alone, so they are stable for the whole engine run.
         if (load_pub_ops) begin
            me_base  <= g_q;
            me_exp   <= {1'b0, a_q};
            me_prime <= p_q;
         end
         if (load_sec_ops) begin
            me_base  <= peer_pub;
            me_exp   <= {1'b0, a_q};
            me_prime <= p_q;
         end
         if (cap_pub) begin
            pub_key   <= me_result;
            pub_valid <= 1'b1;
         end
         if (cap_sec) begin
            secret       <= me_result;
            secret_valid <= 1'b1;
         end
         if (set_err) begin
            error    <= 1'b1;
            err_code <= err_sel;
         end
      end
   end

endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// Scoreboard bench for dh_exchange_ctrl with a behavioural modular_exp model.
module tb_dh_exchange_ctrl;
   import dh_pkg::*;

   localparam int W    = 100;
   localparam int SC   = 2;
   localparam int ACKT = 16;

   localparam int K_PUB = 0;
   localparam int K_SEC = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int           kind;
      logic [127:0] val;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   generator = '0, prime = '0, priv_key = '0, peer_pub = '0;
   logic           peer_valid = 1'b0;
   logic           abort = 1'b0;
   logic           busy, pub_valid, secret_valid, error, me_start;
   logic [W-1:0]   pub_key, secret, me_base, me_prime;
   logic [W:0]     me_exp;
   logic [1:0]     err_code;
   logic [W-1:0]   eng_result = '0;
   logic           eng_dirty = 1'b0;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   dh_exchange_ctrl #(.WIDTH(W), .START_CYCLES(SC), .ACK_TIMEOUT(ACKT)) dut (
      .clk(clk), .rst(rst), .start(start), .generator(generator), .prime(prime),
      .priv_key(priv_key), .peer_pub(peer_pub), .peer_valid(peer_valid), .abort(abort),
      .busy(busy), .pub_key(pub_key), .pub_valid(pub_valid), .secret(secret),
      .secret_valid(secret_valid), .error(error), .err_code(err_code),
      .me_start(me_start), .me_base(me_base), .me_exp(me_exp), .me_prime(me_prime),
      .me_result(eng_result), .me_dirty(eng_dirty)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // ---------------- behavioural engine ----------------
   function automatic logic [W-1:0] modexp(input logic [W-1:0] b_in, input logic [W:0] e,
                                          input logic [W-1:0] m);
      logic [2*W-1:0] r, b;
      r = 1;
      b = {{W{1'b0}}, b_in} % {{W{1'b0}}, m};
      for (int i = 0; i <= W; i++) begin
         if (e[i]) r = (r * b) % {{W{1'b0}}, m};
         b = (b * b) % {{W{1'b0}}, m};
      end
      return r[W-1:0];
   endfunction

   logic eng_silent = 1'b0;
   logic eng_run    = 1'b0;
   logic start_q    = 1'b0;
   int   eng_cnt    = 0;

   // Engine: dirty rises shortly after the start pulse ends, stays high for
   // 40 cycles, then falls with the result presented. A new start resets it.
   always @(posedge clk) begin
      start_q <= me_start;
      if (me_start) begin
         eng_run   <= 1'b0;
         eng_dirty <= 1'b0;
         eng_cnt   <= 0;
      end else if (start_q && !eng_silent) begin
         eng_run <= 1'b1;
         eng_cnt <= 0;
      end else if (eng_run) begin
         eng_cnt <= eng_cnt + 1;
         if (eng_cnt == 1) eng_dirty <= 1'b1;
         if (eng_cnt == 41) begin
            eng_result <= modexp(me_base, me_exp, me_prime);
            eng_dirty  <= 1'b0;
            eng_run    <= 1'b0;
         end
      end
   end

   // ---------------- monitors ----------------
   logic pv_q = 1'b0, sv_q = 1'b0, er_q = 1'b0, ms_q = 1'b0;
   int   hi_len = 0;
   int   me_start_pulses = 0;

   task automatic pop_cmp(input int kind, input logic [127:0] val, input string name);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: unexpected output %0h, no expectation queued", name, val);
      end else begin
         e = sb.pop_front();
         check({name, "_kind"}, kind, e.kind);
         check(name, val, e.val);
      end
   endtask

   always @(negedge clk) begin
      if (pub_valid && !pv_q) pop_cmp(K_PUB, pub_key, "pub_key");
      if (secret_valid && !sv_q) begin
         pop_cmp(K_SEC, secret, "secret");
         check("secret_no_error", error, 1'b0);
      end
      if (error && !er_q) pop_cmp(K_ERR, err_code, "err_code");
      if (me_start) hi_len <= hi_len + 1;
      else hi_len <= 0;
      if (me_start && !ms_q) me_start_pulses <= me_start_pulses + 1;
      if (!me_start && ms_q) check("me_start_len", hi_len, SC);
      pv_q <= pub_valid;
      sv_q <= secret_valid;
      er_q <= error;
      ms_q <= me_start;
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic flag_of(input int which);
      case (which)
         0:       return pub_valid;
         1:       return secret_valid;
         2:       return error;
         default: return eng_dirty;
      endcase
   endfunction

   task automatic wait_flag(input int which, input int budget, input string name);
      int n = 0;
      while (!flag_of(which) && n < budget) begin
         cyc(1);
         n++;
      end
      check(name, flag_of(which), 1'b1);
   endtask

   task automatic start_ex(input logic [W-1:0] g, input logic [W-1:0] p, input logic [W-1:0] a);
      generator = g;
      prime     = p;
      priv_key  = a;
      start     = 1'b1;
      cyc(1);
      start     = 1'b0;
   endtask

   task automatic peer_ex(input logic [W-1:0] b);
      peer_pub   = b;
      peer_valid = 1'b1;
      cyc(1);
      peer_valid = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int pulses_before;
      logic [W-1:0] bad_peers [3];
      bad_peers[0] = W'(23);
      bad_peers[1] = W'(0);
      bad_peers[2] = W'(1);

      cyc(2);
      rst = 1'b1;
      cyc(1);
      check("rst_busy", busy, 1'b0);
      check("rst_pub_valid", pub_valid, 1'b0);
      check("rst_secret_valid", secret_valid, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_err_code", err_code, 2'd0);
      check("rst_me_start", me_start, 1'b0);
      check("rst_pub_key", pub_key, 0);
      check("rst_me_exp", me_exp, 0);

      // peer_valid while IDLE is ignored
      peer_ex(W'(19));
      cyc(1);
      check("idle_peer_busy", busy, 1'b0);
      check("idle_peer_secret_valid", secret_valid, 1'b0);

      // normal exchange: p=23 g=5 a=6 -> A=8, B=19 -> s=2
      sb.push_back('{K_PUB, 128'd8});
      start_ex(W'(5), W'(23), W'(6));
      check("norm_busy", busy, 1'b1);
      wait_flag(0, 200, "norm_pub_wait");
      check("norm_me_exp", me_exp, 128'd6);
      check("norm_me_prime", me_prime, 128'd23);
      check("norm_wait_busy", busy, 1'b1);
      sb.push_back('{K_SEC, 128'd2});
      peer_ex(W'(19));
      wait_flag(1, 200, "norm_sec_wait");
      cyc(1);
      check("norm_done_busy", busy, 1'b0);
      check("norm_done_pub_valid", pub_valid, 1'b1);
      check("norm_done_error", error, 1'b0);

      // bad prime
      pulses_before = me_start_pulses;
      sb.push_back('{K_ERR, 128'd1});
      start_ex(W'(5), W'(2), W'(6));
      check("prime_err_early", error, 1'b0);
      cyc(1);
      check("prime_err", error, 1'b1);
      check("prime_code", err_code, 2'd1);
      cyc(3);
      check("prime_no_me_start", me_start_pulses, pulses_before);
      check("prime_busy", busy, 1'b0);

      // bad peer keys
      foreach (bad_peers[i]) begin
         sb.push_back('{K_PUB, 128'd8});
         start_ex(W'(5), W'(23), W'(6));
         wait_flag(0, 200, "peer_pub_wait");
         sb.push_back('{K_ERR, 128'd2});
         peer_ex(bad_peers[i]);
         wait_flag(2, 5, "peer_err_wait");
         check("peer_err_code", err_code, 2'd2);
         check("peer_pub_kept", pub_valid, 1'b1);
      end

      // engine never acknowledges
      eng_silent = 1'b1;
      sb.push_back('{K_ERR, 128'd3});
      start_ex(W'(5), W'(23), W'(6));
      n = 0;
      while (!me_start && n < 20) begin cyc(1); n++; end
      n = 0;
      while (me_start && n < 20) begin cyc(1); n++; end
      n = 0;
      while (!error && n < 40) begin cyc(1); n++; end
      check("timeout_latency", n, ACKT);
      check("timeout_code", err_code, 2'd3);
      eng_silent = 1'b0;

      // abort during PUB_RUN, then a clean exchange
      start_ex(W'(5), W'(23), W'(6));
      wait_flag(3, 50, "abort_dirty_wait");
      cyc(3);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_pub_valid", pub_valid, 1'b0);
      check("abort_error", error, 1'b0);
      sb.push_back('{K_PUB, 128'd8});
      start_ex(W'(5), W'(23), W'(6));
      wait_flag(0, 200, "abort_restart_wait");

      // async reset during SEC_RUN
      peer_ex(W'(19));
      wait_flag(3, 50, "rst_sec_dirty_wait");
      cyc(5);
      #3;
      rst = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_pub_valid", pub_valid, 1'b0);
      check("arst_pub_key", pub_key, 0);
      check("arst_me_base", me_base, 0);
      check("arst_me_start", me_start, 1'b0);
      cyc(2);
      rst = 1'b1;
      peer_valid = 1'b1;
      peer_pub   = W'(19);
      cyc(3);
      peer_valid = 1'b0;
      check("arst_peer_busy", busy, 1'b0);
      check("arst_peer_secret_valid", secret_valid, 1'b0);
      check("arst_peer_error", error, 1'b0);
      cyc(60);

      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
